// File: rtl/dft_stream_reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dft_stream_reorder_pkg
//  Brief    : Shared defaults, output-order encoding and bit-reversal helper
//             for the DFT stream reorder buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package dft_stream_reorder_pkg;

    localparam int unsigned c_lane_w = 32;  // one complex word per lane
    localparam int unsigned c_n      = 16;
    localparam int unsigned c_p      = 2;

    typedef enum logic {
        ORDER_BITREV  = 1'b0,
        ORDER_NATURAL = 1'b1
    } order_e;

    // Reverses the low log2n bits of idx; upper bits come back as zero.
    function automatic logic [7:0] bitrev(input logic [7:0] idx, input int unsigned log2n);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(log2n)) begin
                r[3'(int'(log2n) - 1 - i)] = idx[3'(i)];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dft_reorder_bank.sv
`default_nettype none
// ============================================================================
//  Module   : dft_reorder_bank
//  Brief    : N-word flop bank with a P-lane beat-addressed write port and a
//             P-lane word-addressed combinational read port.
//  Revision : 1.0 - initial release
// ============================================================================
module dft_reorder_bank
    import dft_stream_reorder_pkg::*;
#(
    parameter int unsigned DATA_W = c_lane_w,
    parameter int unsigned N      = c_n,
    parameter int unsigned P      = c_p,
    parameter int unsigned BEAT_W = 3,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [BEAT_W-1:0]     i_wr_beat,
    input  logic [P*DATA_W-1:0]   i_wr_data,
    input  logic [P*ADDR_W-1:0]   i_rd_addr,
    output logic [P*DATA_W-1:0]   o_rd_data
);

    // Contents deliberately survive reset; only control state is cleared.
    logic [DATA_W-1:0] r_mem [N];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int l = 0; l < int'(P); l++) begin
                r_mem[ADDR_W'(int'(i_wr_beat) * int'(P) + l)] <= i_wr_data[l*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar l = 0; l < int'(P); l++) begin : g_rd
        assign o_rd_data[l*DATA_W +: DATA_W] = r_mem[i_rd_addr[l*ADDR_W +: ADDR_W]];
    end

endmodule
`default_nettype wire

// File: rtl/dft_stream_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : dft_stream_reorder
//  Brief    : Ping-pong frame buffer that re-emits each N-point frame in
//             bit-reversed or natural order, P words per beat.
//  Revision : 1.0 - initial release
// ============================================================================
module dft_stream_reorder
    import dft_stream_reorder_pkg::*;
#(
    parameter int unsigned DATA_W = c_lane_w,
    parameter int unsigned N      = c_n,
    parameter int unsigned P      = c_p
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  next,
    input  logic                  mode,
    input  logic [P*DATA_W-1:0]   X,
    output logic                  next_out,
    output logic [P*DATA_W-1:0]   Y,
    output logic                  err
);

    localparam int unsigned c_k      = N / P;
    localparam int unsigned c_log2n  = $clog2(N);
    localparam int unsigned c_beat_w = (c_k > 1) ? $clog2(c_k) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_k - 1);

    logic                  r_cap_active;
    logic [c_beat_w-1:0]   r_cap_cnt;
    order_e                r_cap_mode;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    order_e                r_drn_mode;
    logic                  r_drn_active;
    logic [c_beat_w-1:0]   r_drn_cnt;
    logic                  r_next_out;
    logic [P*DATA_W-1:0]   r_y;
    logic                  r_err;

    logic                  w_cap_last;
    logic                  w_overrun;
    logic [c_beat_w-1:0]   w_rd_beat;
    logic [P*c_log2n-1:0]  w_rd_addr;
    logic [P*DATA_W-1:0]   w_bank_rd [2];
    logic [P*DATA_W-1:0]   w_rd_data;

    assign w_cap_last = r_cap_active && (r_cap_cnt == c_last_beat);
    assign w_overrun  = next && r_cap_active && !w_cap_last;
    // Beat 0 is fetched on the next_out cycle so output beats follow without a gap.
    assign w_rd_beat  = r_next_out ? '0 : r_drn_cnt;
    assign w_rd_data  = r_rd_bank ? w_bank_rd[1] : w_bank_rd[0];

    for (genvar l = 0; l < int'(P); l++) begin : g_rd_addr
        logic [c_log2n-1:0] w_pos;
        assign w_pos = c_log2n'(int'(w_rd_beat) * int'(P) + l);
        assign w_rd_addr[l*c_log2n +: c_log2n] = (r_drn_mode == ORDER_NATURAL)
            ? w_pos : c_log2n'(bitrev(8'(w_pos), c_log2n));
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dft_reorder_bank #(
            .DATA_W (DATA_W),
            .N      (N),
            .P      (P),
            .BEAT_W (c_beat_w),
            .ADDR_W (c_log2n)
        ) u_bank (
            .clk       (clk),
            .i_wr_en   (r_cap_active && (r_wr_bank == 1'(b))),
            .i_wr_beat (r_cap_cnt),
            .i_wr_data (X),
            .i_rd_addr (w_rd_addr),
            .o_rd_data (w_bank_rd[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_active <= 1'b0;
            r_cap_cnt    <= '0;
            r_cap_mode   <= ORDER_BITREV;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_drn_mode   <= ORDER_BITREV;
            r_drn_active <= 1'b0;
            r_drn_cnt    <= '0;
            r_next_out   <= 1'b0;
            r_y          <= '0;
            r_err        <= 1'b0;
        end else begin
            r_next_out <= 1'b0;

            // A new next always restarts capture; mid-frame it drops the partial frame.
            if (next) begin
                r_cap_active <= 1'b1;
                r_cap_cnt    <= '0;
                r_cap_mode   <= order_e'(mode);
                if (w_overrun) begin
                    r_err <= 1'b1;
                end
            end else if (r_cap_active) begin
                if (w_cap_last) begin
                    r_cap_active <= 1'b0;
                end else begin
                    r_cap_cnt <= r_cap_cnt + 1'b1;
                end
            end

            if (w_cap_last) begin
                r_next_out <= 1'b1;
                r_wr_bank  <= ~r_wr_bank;
                r_rd_bank  <= r_wr_bank;
                r_drn_mode <= r_cap_mode;
            end

            if (r_next_out) begin
                r_y          <= w_rd_data;
                r_drn_cnt    <= c_beat_w'(1);
                r_drn_active <= (c_k > 1);
            end else if (r_drn_active) begin
                r_y       <= w_rd_data;
                r_drn_cnt <= r_drn_cnt + 1'b1;
                if (r_drn_cnt == c_last_beat) begin
                    r_drn_active <= 1'b0;
                end
            end else begin
                r_y <= '0;
            end
        end
    end

    assign next_out = r_next_out;
    assign Y        = r_y;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dft_stream_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dft_stream_reorder
//  Brief    : Scheduled directed frames with a queue-based output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dft_stream_reorder;

    localparam int c_len = 170;

    logic        clk = 1'b0;
    logic        reset;
    logic        next;
    logic        mode;
    logic [63:0] X;
    logic        next_out;
    logic [63:0] Y;
    logic        err;

    typedef struct {
        int          cyc;
        logic [63:0] y;
    } exp_t;

    exp_t eq[$];
    int   nq[$];

    logic        s_next [c_len];
    logic        s_mode [c_len];
    logic        s_rst  [c_len];
    logic        s_err  [c_len];
    logic [63:0] s_x    [c_len];

    int cyc      = -1;
    int checks   = 0;
    int errors   = 0;
    bit run_done = 1'b0;

    // Hand-written 4-bit reversed order for N = 16.
    int c_brev [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dft_stream_reorder #(
        .DATA_W (32),
        .N      (16),
        .P      (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .next     (next),
        .mode     (mode),
        .X        (X),
        .next_out (next_out),
        .Y        (Y),
        .err      (err)
    );

    function automatic logic [31:0] word(input int f, input int i);
        return {8'(f), 8'(i), 8'(240 - i), 8'(f + i)};
    endfunction

    // Schedules one frame; expectations at or after cycle 'cut' are not queued.
    task automatic frame_at(input int t0, input bit m, input int f, input int nbeats, input int cut);
        exp_t e;
        int   i0;
        int   i1;
        s_next[t0] = 1'b1;
        s_mode[t0] = m;
        for (int b = 0; b < nbeats; b++) begin
            s_x[t0 + 1 + b]    = {word(f, 2*b + 1), word(f, 2*b)};
            s_mode[t0 + 1 + b] = ~m;
        end
        if (nbeats == 8) begin
            if (t0 + 9 < cut) nq.push_back(t0 + 9);
            for (int b = 0; b < 8; b++) begin
                i0 = m ? 2*b     : c_brev[2*b];
                i1 = m ? 2*b + 1 : c_brev[2*b + 1];
                e.cyc = t0 + 10 + b;
                e.y   = {word(f, i1), word(f, i0)};
                if (e.cyc < cut) eq.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < c_len && !run_done) begin
            while (nq.size() > 0 && nq[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL next_out_missing cyc=%0d got=0 want=1", nq.pop_front());
            end
            checks++;
            if (nq.size() > 0 && nq[0] == cyc) begin
                void'(nq.pop_front());
                if (next_out !== 1'b1) begin
                    errors++;
                    $display("FAIL next_out cyc=%0d got=%b want=1", cyc, next_out);
                end
            end else if (next_out !== 1'b0) begin
                errors++;
                $display("FAIL next_out_spurious cyc=%0d got=%b want=0", cyc, next_out);
            end

            checks++;
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                exp_t e;
                e = eq.pop_front();
                if (Y !== e.y) begin
                    errors++;
                    $display("FAIL y_beat cyc=%0d got=%h want=%h", cyc, Y, e.y);
                end
            end else if (Y !== 64'h0) begin
                errors++;
                $display("FAIL y_idle cyc=%0d got=%h want=0", cyc, Y);
            end

            checks++;
            if (err !== s_err[cyc]) begin
                errors++;
                $display("FAIL err cyc=%0d got=%b want=%b", cyc, err, s_err[cyc]);
            end
        end
    end

    initial begin
        for (int t = 0; t < c_len; t++) begin
            s_next[t] = 1'b0;
            s_mode[t] = 1'b0;
            s_rst[t]  = 1'b0;
            s_err[t]  = 1'b0;
            s_x[t]    = 64'h0;
        end
        for (int t = 0; t < 3; t++) s_rst[t] = 1'b1;

        frame_at(5,  1'b0, 1, 8, c_len);   // bit-reversed
        frame_at(30, 1'b1, 2, 8, c_len);   // natural
        frame_at(55, 1'b0, 3, 8, c_len);   // back-to-back pair
        frame_at(63, 1'b1, 4, 8, c_len);
        frame_at(90, 1'b1, 5, 4, c_len);   // overrun: partial frame dropped
        frame_at(94, 1'b0, 6, 8, c_len);
        for (int t = 95; t < 132; t++) s_err[t] = 1'b1;
        frame_at(120, 1'b0, 7, 8, 132);    // reset mid-drain at 132
        s_rst[132] = 1'b1;
        s_rst[133] = 1'b1;
        frame_at(140, 1'b1, 8, 8, c_len);

        reset = 1'b0;
        next  = 1'b0;
        mode  = 1'b0;
        X     = 64'h0;
        for (int t = 0; t < c_len; t++) begin
            @(posedge clk);
            #1;
            reset = !s_rst[t];
            next  = s_next[t];
            mode  = s_mode[t];
            X     = s_x[t];
        end
        @(posedge clk);
        #1;
        run_done = 1'b1;

        checks++;
        if (eq.size() != 0 || nq.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got=%0d/%0d want=0/0", eq.size(), nq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
